// File: rtl/cpu_pkg.sv
// Core-wide constants and types shared by the register file and its storage cells.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       xword_t;
    typedef logic [REG_ADDR_W-1:0] regaddr_t;

endpackage

// File: rtl/reg_en.sv
// One storage word with load enable and asynchronous clear to zero.
module reg_en
    import cpu_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Hold unless enabled.
    always_comb begin
        word_d = word_q;
        if (en) begin
            word_d = d;
        end else begin
            word_d = word_q;
        end
    end

    // Storage flop with async clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/reg_file.sv
// Multi-port register file: one synchronous write port, NRD combinational read ports,
// optional hardwired-zero entry 0 and write-to-read bypass.
module reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH    = XLEN,
    parameter int DEPTH    = NREGS,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*WIDTH-1:0]  rdata
);

    logic [DEPTH-1:0][WIDTH-1:0] entry_s;

    // Out-of-range write addresses match no entry, so they are dropped naturally.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign entry_s[i] = '0;
        end else begin : g_flop
            logic wen_s;
            assign wen_s = we & (waddr == ADDR_W'(i)) & ~rst;
            reg_en #(.WIDTH(WIDTH)) u_word (
                .clk (clk),
                .rst (rst),
                .en  (wen_s),
                .d   (wdata),
                .q   (entry_s[i])
            );
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic [WIDTH-1:0]  rd_s;

        assign ra_s = raddr[p*ADDR_W +: ADDR_W];

        // Lane priority: reset, range, x0, bypass, stored word.
        always_comb begin
            rd_s = '0;
            if (rst) begin
                rd_s = '0;
            end else if (int'(ra_s) >= DEPTH) begin
                rd_s = '0;
            end else if (ZERO_REG && (ra_s == '0)) begin
                rd_s = '0;
            end else if (BYPASS && we && (ra_s == waddr)) begin
                rd_s = wdata;
            end else begin
                rd_s = entry_s[ra_s];
            end
        end

        assign rdata[p*WIDTH +: WIDTH] = rd_s;
    end

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: default config, no-x0/no-bypass config, and a
// 64-bit/24-entry/3-port config with a scoreboard-checked random stream.
module tb_reg_file;

    logic clk;
    logic rst;

    logic        we_a, we_b, we_c;
    logic [4:0]  waddr_a, waddr_b, waddr_c;
    logic [31:0] wdata_a, wdata_b;
    logic [63:0] wdata_c;
    logic [9:0]  raddr_a, raddr_b;
    logic [14:0] raddr_c;
    logic [63:0] rdata_a, rdata_b;
    logic [191:0] rdata_c;

    int n_checks;
    int n_fail;

    logic [63:0] mdl [24];

    reg_file u_a (
        .clk(clk), .rst(rst), .we(we_a), .waddr(waddr_a), .wdata(wdata_a),
        .raddr(raddr_a), .rdata(rdata_a)
    );

    reg_file #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
        .clk(clk), .rst(rst), .we(we_b), .waddr(waddr_b), .wdata(wdata_b),
        .raddr(raddr_b), .rdata(rdata_b)
    );

    reg_file #(.WIDTH(64), .DEPTH(24), .NRD(3)) u_c (
        .clk(clk), .rst(rst), .we(we_c), .waddr(waddr_c), .wdata(wdata_c),
        .raddr(raddr_c), .rdata(rdata_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we_a = 1'b1; waddr_a = a; wdata_a = d;
        @(posedge clk); #1;
        we_a = 1'b0;
    endtask

    task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we_b = 1'b1; waddr_b = a; wdata_b = d;
        @(posedge clk); #1;
        we_b = 1'b0;
    endtask

    task automatic wr_c(input logic [4:0] a, input logic [63:0] d);
        @(negedge clk);
        we_c = 1'b1; waddr_c = a; wdata_c = d;
        @(posedge clk); #1;
        we_c = 1'b0;
    endtask

    task automatic test_reset();
        raddr_c = {5'd23, 5'd2, 5'd1};
        #1;
        n_checks++;
        if (rdata_c !== 192'd0) begin
            n_fail++; $display("FAIL init_c: got %h exp 0", rdata_c);
        end
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we_a = 1'b1; waddr_a = 5'(i); wdata_a = 32'hA5A5A5A5;
        end
        @(negedge clk);
        we_a = 1'b0;
        raddr_a = {5'd31, 5'd3};
        #1;
        n_checks++;
        if (rdata_a !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_fail++; $display("FAIL preload: got %h exp a5a5a5a5a5a5a5a5", rdata_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL rst_during: got %h exp 0", rdata_a);
        end
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL rst_after: got %h exp 0", rdata_a);
        end
        for (int i = 0; i < 32; i++) begin
            raddr_a = {5'd0, 5'(i)};
            #1;
            n_checks++;
            if (rdata_a[31:0] !== 32'd0) begin
                n_fail++; $display("FAIL rst_entry%0d: got %h exp 0", i, rdata_a[31:0]);
            end
        end
    endtask

    task automatic test_write_read();
        wr_a(5'd5, 32'hDEADBEEF);
        raddr_a = {5'd5, 5'd5};
        #1;
        n_checks++;
        if (rdata_a !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL wr_x5: got %h exp deadbeefdeadbeef", rdata_a);
        end
        wr_a(5'd6, 32'h00000001);
        raddr_a = {5'd6, 5'd5};
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL x5_kept: got %h exp deadbeef", rdata_a[31:0]);
        end
        n_checks++;
        if (rdata_a[63:32] !== 32'h00000001) begin
            n_fail++; $display("FAIL wr_x6: got %h exp 00000001", rdata_a[63:32]);
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        we_a = 1'b1; waddr_a = 5'd0; wdata_a = 32'hFFFFFFFF; raddr_a = 10'd0;
        we_b = 1'b1; waddr_b = 5'd0; wdata_b = 32'hFFFFFFFF; raddr_b = 10'd0;
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL x0_bypass: got %h exp 0", rdata_a);
        end
        n_checks++;
        if (rdata_b[31:0] !== 32'd0) begin
            n_fail++; $display("FAIL nz_x0_before: got %h exp 0", rdata_b[31:0]);
        end
        @(posedge clk); #1;
        we_a = 1'b0; we_b = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL x0_after: got %h exp 0", rdata_a);
        end
        n_checks++;
        if (rdata_b !== {32'hFFFFFFFF, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL nz_x0_after: got %h exp ffffffffffffffff", rdata_b);
        end
    endtask

    task automatic test_bypass();
        wr_a(5'd7, 32'h00000011);
        wr_b(5'd7, 32'h00000011);
        @(negedge clk);
        we_a = 1'b1; waddr_a = 5'd7; wdata_a = 32'h00000022; raddr_a = {5'd8, 5'd7};
        we_b = 1'b1; waddr_b = 5'd7; wdata_b = 32'h00000022; raddr_b = {5'd7, 5'd7};
        #1;
        n_checks++;
        if (rdata_a !== {32'h00000000, 32'h00000022}) begin
            n_fail++; $display("FAIL byp_before: got %h exp 0000000000000022", rdata_a);
        end
        n_checks++;
        if (rdata_b !== {32'h00000011, 32'h00000011}) begin
            n_fail++; $display("FAIL nobyp_before: got %h exp 0000001100000011", rdata_b);
        end
        @(posedge clk); #1;
        we_a = 1'b0; we_b = 1'b0;
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h00000022) begin
            n_fail++; $display("FAIL byp_after: got %h exp 00000022", rdata_a[31:0]);
        end
        n_checks++;
        if (rdata_b !== {32'h00000022, 32'h00000022}) begin
            n_fail++; $display("FAIL nobyp_after: got %h exp 0000002200000022", rdata_b);
        end
    endtask

    task automatic test_reset_vs_write();
        @(negedge clk);
        rst = 1'b1;
        we_a = 1'b1; waddr_a = 5'd3; wdata_a = 32'h00000033; raddr_a = {5'd5, 5'd3};
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL rstwr_during: got %h exp 0", rdata_a);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; we_a = 1'b0;
        #1;
        n_checks++;
        if (rdata_a !== 64'd0) begin
            n_fail++; $display("FAIL rstwr_x3: got %h exp 0", rdata_a);
        end
        wr_a(5'd3, 32'h00000033);
        #1;
        n_checks++;
        if (rdata_a[31:0] !== 32'h00000033) begin
            n_fail++; $display("FAIL post_rst_wr: got %h exp 00000033", rdata_a[31:0]);
        end
    endtask

    task automatic test_params();
        logic [63:0] e;
        logic [4:0]  ra;
        mdl[0] = 64'd0;
        for (int i = 1; i < 24; i++) begin
            mdl[i] = {32'(i), 32'hC0DE0000 | 32'(i)};
            wr_c(5'(i), mdl[i]);
        end
        @(negedge clk);
        we_c = 1'b1; waddr_c = 5'd25; wdata_c = 64'hFFFFFFFFFFFFFFFF;
        raddr_c = {5'd25, 5'd24, 5'd25};
        #1;
        n_checks++;
        if (rdata_c !== 192'd0) begin
            n_fail++; $display("FAIL oor_bypass: got %h exp 0", rdata_c);
        end
        @(posedge clk); #1;
        we_c = 1'b0;
        #1;
        n_checks++;
        if (rdata_c !== 192'd0) begin
            n_fail++; $display("FAIL oor_read: got %h exp 0", rdata_c);
        end
        for (int i = 0; i < 24; i++) begin
            raddr_c = {5'd31, 5'd25, 5'(i)};
            #1;
            n_checks++;
            if (rdata_c !== {128'd0, mdl[i]}) begin
                n_fail++; $display("FAIL oor_entry%0d: got %h exp %h", i, rdata_c, mdl[i]);
            end
        end
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            we_c    = 1'($urandom_range(0, 1));
            waddr_c = 5'($urandom_range(0, 31));
            wdata_c = {$urandom, $urandom};
            for (int p = 0; p < 3; p++) begin
                if ($urandom_range(0, 3) == 0) raddr_c[p*5 +: 5] = waddr_c;
                else raddr_c[p*5 +: 5] = 5'($urandom_range(0, 31));
            end
            #1;
            for (int p = 0; p < 3; p++) begin
                ra = raddr_c[p*5 +: 5];
                if (ra >= 5'd24 || ra == 5'd0) e = 64'd0;
                else if (we_c && ra == waddr_c) e = wdata_c;
                else e = mdl[ra];
                n_checks++;
                if (rdata_c[p*64 +: 64] !== e) begin
                    n_fail++;
                    $display("FAIL rnd c%0d p%0d a%0d: got %h exp %h", n, p, ra, rdata_c[p*64 +: 64], e);
                end
            end
            @(posedge clk);
            if (we_c && waddr_c < 5'd24 && waddr_c != 5'd0) mdl[waddr_c] = wdata_c;
        end
        @(negedge clk);
        we_c = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        we_a = 1'b0; waddr_a = 5'd0; wdata_a = 32'd0; raddr_a = 10'd0;
        we_b = 1'b0; waddr_b = 5'd0; wdata_b = 32'd0; raddr_b = 10'd0;
        we_c = 1'b0; waddr_c = 5'd0; wdata_c = 64'd0; raddr_c = 15'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_write_read();
        test_x0();
        test_bypass();
        test_reset_vs_write();
        test_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
